bkm_ctrl_scheduler: RTL and testbench

//  Control plane behind monitor_interface. Decodes completed monitor bus transactions into an 8-entry register bank.

---
 rtl/bkm_pkg.sv | 26 ++
 rtl/bkm_rr_arbiter.sv | 38 +++
 rtl/bkm_ctrl_scheduler.sv | 157 +++++++++++++++
 tb/tb_bkm_ctrl_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkm_pkg.sv
// bkm_pkg: shared constants for the BKM card control plane.
//   Register addresses, CTRL bit positions, IRQ FSM state codes and bus widths.
package bkm_pkg;

  localparam int unsigned REG_W = 8;
  localparam int unsigned PTR_W = 3;

  localparam logic [PTR_W-1:0] REG_ID   = 3'd0;
  localparam logic [PTR_W-1:0] REG_CTRL = 3'd1;
  localparam logic [PTR_W-1:0] REG_VEC  = 3'd2;
  localparam logic [PTR_W-1:0] REG_MASK = 3'd3;
  localparam logic [PTR_W-1:0] REG_PEND = 3'd4;
  localparam logic [PTR_W-1:0] REG_PCLR = 3'd5;

  localparam int unsigned CTRL_HD_SD    = 0;
  localparam int unsigned CTRL_RGB_COMP = 1;
  localparam int unsigned CTRL_INT_EXT  = 2;
  localparam int unsigned CTRL_VIDEO_OE = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARB      = 3'd1;
  localparam logic [2:0] ST_ASSERT   = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_HOLDOFF  = 3'd4;

endpackage

// File: rtl/bkm_rr_arbiter.sv
// bkm_rr_arbiter: combinational round-robin pick over NUM_EVT requesters.
//   req      in   NUM_EVT  request vector
//   last_idx in   3        index granted last time; search starts one above it
//   grant    out  NUM_EVT  one-hot grant (all zero when valid=0)
//   idx      out  3        granted index
//   valid    out  1        some request was granted
module bkm_rr_arbiter
  import bkm_pkg::*;
#(
  parameter int unsigned NUM_EVT = 4
) (
  input  logic [NUM_EVT-1:0] req,
  input  logic [PTR_W-1:0]   last_idx,
  output logic [NUM_EVT-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  logic [7:0]       req_ext;
  logic [PTR_W-1:0] cand;

  // Walk last_idx+1, last_idx+2, ... (mod NUM_EVT); first requester wins.
  always_comb begin
    req_ext = 8'(req);
    idx     = '0;
    valid   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_EVT; k++) begin
      cand = PTR_W'((32'(last_idx) + k) % NUM_EVT);
      if (!valid && req_ext[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    grant = valid ? (NUM_EVT'(1) << idx) : '0;
  end

endmodule

// File: rtl/bkm_ctrl_scheduler.sv
// bkm_ctrl_scheduler: register bank, video-path selects and IRQ scheduler
// behind monitor_interface.
//   clk_20mhz  in   1        clock
//   reset      in   1        synchronous, active-high
//   bus_stb    in   1        completed monitor bus cycle
//   bus_ax_d   in   1        1 = address cycle, 0 = data cycle
//   bus_wr     in   1        1 = write, 0 = read
//   bus_wdata  in   8        write data / address byte
//   bus_rdata  out  8        read data at current pointer (combinational)
//   evt_pulse  in   NUM_EVT  event request pulses
//   irq_req    out  1        interrupt request
//   hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x  out  CTRL[3:0]
module bkm_ctrl_scheduler
  import bkm_pkg::*;
#(
  parameter int unsigned NUM_EVT     = 4,
  parameter logic [7:0]  CARD_ID     = 8'h68,
  parameter int unsigned HOLDOFF_CYC = 16
) (
  input  logic               clk_20mhz,
  input  logic               reset,
  input  logic               bus_stb,
  input  logic               bus_ax_d,
  input  logic               bus_wr,
  input  logic [REG_W-1:0]   bus_wdata,
  output logic [REG_W-1:0]   bus_rdata,
  input  logic [NUM_EVT-1:0] evt_pulse,
  output logic               irq_req,
  output logic               hd_sd_x,
  output logic               rgb_comp_x,
  output logic               int_ext_x,
  output logic               video_oe_x
);

  localparam int unsigned CNT_W = $clog2(HOLDOFF_CYC + 1);
  localparam logic [REG_W-1:0] MASK_VALID = 8'((9'd1 << NUM_EVT) - 9'd1);

  logic [PTR_W-1:0]   ptr;
  logic [3:0]         ctrl;
  logic [REG_W-1:0]   mask;
  logic [NUM_EVT-1:0] pend;
  logic [PTR_W-1:0]   vec_idx, vec_nxt;
  logic [PTR_W-1:0]   last_idx, last_nxt;
  logic [2:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               irq_nxt;

  logic               data_cyc, vec_rd;
  logic [NUM_EVT-1:0] arb_req, arb_grant, grant_clr, pclr_bits;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;

  assign data_cyc  = bus_stb & ~bus_ax_d;
  assign vec_rd    = data_cyc & ~bus_wr & (ptr == REG_VEC);
  assign pclr_bits = (data_cyc & bus_wr & (ptr == REG_PCLR)) ? bus_wdata[NUM_EVT-1:0] : '0;
  assign arb_req   = pend & mask[NUM_EVT-1:0];

  bkm_rr_arbiter #(.NUM_EVT(NUM_EVT)) u_arb (
    .req      (arb_req),
    .last_idx (last_idx),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .valid    (arb_valid)
  );

  // Read mux: side-effect free; the ack is detected separately via vec_rd.
  always_comb begin
    bus_rdata = '0;
    case (ptr)
      REG_ID:   bus_rdata = CARD_ID;
      REG_CTRL: bus_rdata = {4'b0, ctrl};
      REG_VEC:  bus_rdata = {irq_req, 4'b0, vec_idx};
      REG_MASK: bus_rdata = mask;
      REG_PEND: bus_rdata = 8'(pend);
      default:  bus_rdata = '0;
    endcase
  end

  // IRQ scheduler next-state logic.
  always_comb begin
    state_nxt = state;
    irq_nxt   = irq_req;
    cnt_nxt   = cnt;
    vec_nxt   = vec_idx;
    last_nxt  = last_idx;
    grant_clr = '0;
    case (state)
      ST_IDLE: begin
        if (|arb_req) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        // Requests may vanish between IDLE and ARB (PCLR / MASK write).
        if (arb_valid) begin
          vec_nxt   = arb_idx;
          last_nxt  = arb_idx;
          grant_clr = arb_grant;
          irq_nxt   = 1'b1;
          state_nxt = ST_ASSERT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ASSERT: state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (vec_rd) begin
          irq_nxt   = 1'b0;
          cnt_nxt   = CNT_W'(HOLDOFF_CYC);
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // All state; new events win over same-cycle clears.
  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      ptr      <= '0;
      ctrl     <= 4'hF;
      mask     <= '0;
      pend     <= '0;
      vec_idx  <= '0;
      last_idx <= PTR_W'(NUM_EVT - 1);
      state    <= ST_IDLE;
      cnt      <= '0;
      irq_req  <= 1'b0;
    end else begin
      if (bus_stb && bus_ax_d) begin
        ptr <= bus_wdata[PTR_W-1:0];
      end else if (data_cyc) begin
        ptr <= ptr + PTR_W'(1);
        if (bus_wr && ptr == REG_CTRL) ctrl <= bus_wdata[3:0];
        if (bus_wr && ptr == REG_MASK) mask <= bus_wdata & MASK_VALID;
      end
      pend     <= (pend & ~pclr_bits & ~grant_clr) | evt_pulse;
      vec_idx  <= vec_nxt;
      last_idx <= last_nxt;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      irq_req  <= irq_nxt;
    end
  end

  assign hd_sd_x    = ctrl[CTRL_HD_SD];
  assign rgb_comp_x = ctrl[CTRL_RGB_COMP];
  assign int_ext_x  = ctrl[CTRL_INT_EXT];
  assign video_oe_x = ctrl[CTRL_VIDEO_OE];

endmodule

// File: tb/tb_bkm_ctrl_scheduler.sv
// Testbench for bkm_ctrl_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-timeline model of the register bank and IRQ scheduler.
module tb_bkm_ctrl_scheduler;

  localparam int unsigned NUM_EVT = 4;
  localparam int          HOLD    = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               bus_stb = 1'b0, bus_ax_d = 1'b0, bus_wr = 1'b0;
  logic [7:0]         bus_wdata = '0;
  logic [7:0]         bus_rdata;
  logic [NUM_EVT-1:0] evt_pulse = '0;
  logic               irq_req, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x;

  always #5 clk = ~clk;

  bkm_ctrl_scheduler #(.NUM_EVT(NUM_EVT), .CARD_ID(8'h68), .HOLDOFF_CYC(HOLD)) dut (
    .clk_20mhz  (clk),
    .reset      (reset),
    .bus_stb    (bus_stb),
    .bus_ax_d   (bus_ax_d),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .evt_pulse  (evt_pulse),
    .irq_req    (irq_req),
    .hd_sd_x    (hd_sd_x),
    .rgb_comp_x (rgb_comp_x),
    .int_ext_x  (int_ext_x),
    .video_oe_x (video_oe_x)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Timeline view: an arbitration cycle follows the first idle cycle that sees
  // a masked-in pending bit; the IRQ is up from the cycle after that until the
  // first VEC read that is not in its first cycle; then HOLD quiet cycles.
  bit                 m_valid = 1'b0;
  logic [2:0]         m_ptr, m_vec, m_last;
  logic [3:0]         m_ctrl;
  logic [7:0]         m_mask;
  logic [NUM_EVT-1:0] m_pend, m_req, m_gclr, m_pclr;
  bit                 m_irq, m_arb_now, m_found;
  int                 m_age, m_hold;
  int unsigned        mc;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_ptr = 3'd0; m_ctrl = 4'hF; m_mask = 8'h00; m_pend = '0;
      m_vec = 3'd0; m_last = 3'(NUM_EVT - 1);
      m_irq = 1'b0; m_arb_now = 1'b0; m_age = 0; m_hold = 0;
    end else if (m_valid) begin
      m_req  = m_pend & m_mask[NUM_EVT-1:0];
      m_gclr = '0;
      if (m_arb_now) begin
        m_arb_now = 1'b0;
        m_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_EVT; k++) begin
          mc = (32'(m_last) + k) % NUM_EVT;
          if (!m_found && ((m_req >> mc) & 1) != 0) begin
            m_found = 1'b1;
            m_gclr  = NUM_EVT'(1) << mc;
            m_vec   = 3'(mc);
          end
        end
        if (m_found) begin
          m_last = m_vec; m_irq = 1'b1; m_age = 0;
        end
      end else if (m_irq) begin
        if (bus_stb && !bus_ax_d && !bus_wr && m_ptr == 3'd2 && m_age >= 1) begin
          m_irq = 1'b0; m_hold = HOLD;
        end
        m_age++;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (m_req != 0) begin
        m_arb_now = 1'b1;
      end
      m_pclr = (bus_stb && !bus_ax_d && bus_wr && m_ptr == 3'd5) ? bus_wdata[NUM_EVT-1:0] : '0;
      m_pend = (m_pend & ~m_pclr & ~m_gclr) | evt_pulse;
      if (bus_stb && !bus_ax_d && bus_wr) begin
        if (m_ptr == 3'd1) m_ctrl = bus_wdata[3:0];
        if (m_ptr == 3'd3) m_mask = bus_wdata & 8'h0F;
      end
      if (bus_stb) m_ptr = bus_ax_d ? bus_wdata[2:0] : m_ptr + 3'd1;
    end
  end

  function automatic logic [7:0] model_rdata();
    case (m_ptr)
      3'd0:    return 8'h68;
      3'd1:    return {4'b0, m_ctrl};
      3'd2:    return {m_irq, 4'b0, m_vec};
      3'd3:    return m_mask;
      3'd4:    return 8'(m_pend);
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle compare, mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_rdata", bus_rdata, model_rdata());
      check("cyc_irq", irq_req, m_irq);
      check("cyc_selects", {video_oe_x, int_ext_x, rgb_comp_x, hd_sd_x}, m_ctrl);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_stb = 1'b0; bus_ax_d = 1'b0; bus_wr = 1'b0; bus_wdata = '0; evt_pulse = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic bus_addr(input logic [7:0] a);
    bus_stb = 1'b1; bus_ax_d = 1'b1; bus_wr = 1'b0; bus_wdata = a;
    tick();
    bus_stb = 1'b0; bus_ax_d = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] d);
    bus_stb = 1'b1; bus_ax_d = 1'b0; bus_wr = 1'b1; bus_wdata = d;
    tick();
    bus_stb = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [7:0] exp);
    bus_stb = 1'b1; bus_ax_d = 1'b0; bus_wr = 1'b0;
    @(negedge clk);
    check(name, bus_rdata, exp);
    tick();
    bus_stb = 1'b0;
  endtask

  // Waits (bounded) for irq_req, then acks via a VEC read; returns the VEC byte.
  task automatic ack_irq(output logic [7:0] v);
    int w;
    w = 0;
    while (irq_req !== 1'b1 && w < 60) begin tick(); w++; end
    check("irq_wait", irq_req, 1'b1);
    tick();
    bus_addr(8'h02);
    bus_stb = 1'b1; bus_ax_d = 1'b0; bus_wr = 1'b0;
    @(negedge clk);
    v = bus_rdata;
    tick();
    bus_stb = 1'b0;
  endtask

  logic [7:0] v;
  int         r;

  initial begin
    idle_inputs();

    // Reset state and ID.
    reset_dut();
    check("rst_irq", irq_req, 1'b0);
    check("rst_selects", {video_oe_x, int_ext_x, rgb_comp_x, hd_sd_x}, 4'hF);
    bus_read("id", 8'h68);

    // Pointer, CTRL write and select outputs, wrap 7->0.
    bus_addr(8'h01);
    bus_write(8'h05);
    bus_addr(8'h01);
    bus_read("ctrl_rd", 8'h05);
    check("hd_sd_x", hd_sd_x, 1'b1);
    check("rgb_comp_x", rgb_comp_x, 1'b0);
    check("int_ext_x", int_ext_x, 1'b1);
    check("video_oe_x", video_oe_x, 1'b0);
    bus_addr(8'h07);
    bus_read("reg7", 8'h00);
    bus_read("wrap_id", 8'h68);

    // Single IRQ: latency n+3, ack, holdoff.
    bus_addr(8'h03); bus_write(8'h01); bus_addr(8'h02);
    evt_pulse = 4'b0001; tick(); evt_pulse = '0;
    check("lat_n1", irq_req, 1'b0); tick();
    check("lat_n2", irq_req, 1'b0); tick();
    check("lat_n3", irq_req, 1'b1);
    check("model_lat_n3", m_irq, 1'b1);
    tick();
    bus_read("vec_ack", 8'h80);
    check("irq_drop", irq_req, 1'b0);
    evt_pulse = 4'b0001;
    for (int i = 0; i < HOLD; i++) begin
      check("holdoff_quiet", irq_req, 1'b0);
      tick();
      evt_pulse = '0;
    end
    ack_irq(v);
    check("vec_second", v, 8'h80);

    // Round-robin from a fresh reset.
    reset_dut();
    bus_addr(8'h03); bus_write(8'hFF);
    bus_addr(8'h03); bus_read("mask_rd", 8'h0F);
    evt_pulse = 4'b1111; tick(); evt_pulse = '0;
    for (int i = 0; i < 4; i++) begin
      ack_irq(v);
      check("rr_vec", v, 8'h80 | 8'(i));
    end
    bus_addr(8'h04); bus_read("rr_pend_end", 8'h00);

    // Masking and set/clear collision.
    bus_addr(8'h03); bus_write(8'h00);
    evt_pulse = 4'b0100; tick(); evt_pulse = '0;
    for (int i = 0; i < 5; i++) begin check("masked_noirq", irq_req, 1'b0); tick(); end
    bus_addr(8'h04); bus_read("pend_masked", 8'h04);
    bus_addr(8'h05);
    evt_pulse = 4'b0100; bus_write(8'h04); evt_pulse = '0;
    bus_addr(8'h04); bus_read("pend_collide", 8'h04);
    bus_addr(8'h05); bus_write(8'h04);
    bus_addr(8'h04); bus_read("pend_cleared", 8'h00);
    bus_addr(8'h05); bus_read("pclr_rd", 8'h00);

    // Reset while the IRQ is asserted.
    bus_addr(8'h01); bus_write(8'h0A);
    bus_addr(8'h03); bus_write(8'h01);
    evt_pulse = 4'b0011; tick(); evt_pulse = '0;
    for (int w = 0; w < 10 && irq_req !== 1'b1; w++) tick();
    tick();
    check("t6_irq_up", irq_req, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_irq_rst", irq_req, 1'b0);
    check("t6_selects", {video_oe_x, int_ext_x, rgb_comp_x, hd_sd_x}, 4'hF);
    bus_addr(8'h04); bus_read("t6_pend", 8'h00);
    for (int i = 0; i < 25; i++) tick();
    check("t6_no_replay", irq_req, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      r = $urandom_range(0, 99);
      if (r < 15) begin
        bus_stb = 1'b1; bus_ax_d = 1'b1;
        bus_wdata = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom);
      end else if (r < 50) begin
        bus_stb = 1'b1; bus_ax_d = 1'b0;
        bus_wr = 1'($urandom_range(0, 1));
        bus_wdata = 8'($urandom);
      end
      evt_pulse = ($urandom_range(0, 5) == 0) ? NUM_EVT'($urandom) : '0;
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
